// File: rtl/vmem_issue_queue.sv
// Vector memory front-end: validates load/store commands, converts byte units to words,
// queues them for in-order issue and tracks issued operations until their in-order completion.
module vmem_issue_queue #(
  parameter  int unsigned ADDR_RANGE      = 32768,
  parameter  int unsigned MEMORY_BITS     = 32,
  parameter  int unsigned DEPTH           = 4,
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  int unsigned ID_BITS         = 5,
  localparam int unsigned AW              = $clog2(ADDR_RANGE),
  localparam int unsigned WB              = $clog2(MEMORY_BITS / 8)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_load,
  input  logic               in_store,
  input  logic [1:0]         in_mode,
  input  logic [2:0]         in_sew,
  input  logic [2:0]         in_idx_sew,
  input  logic [AW+WB-1:0]   in_addr,
  input  logic [AW+WB-1:0]   in_stride,
  input  logic [ID_BITS-1:0] in_dest_id,
  input  logic               flush,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_operation,
  output logic [1:0]         req_mode,
  output logic [2:0]         req_sew,
  output logic [2:0]         req_idx_sew,
  output logic [AW-1:0]      req_addr,
  output logic [AW-1:0]      req_stride,
  input  logic               done_in,
  output logic               cpl_valid,
  output logic [ID_BITS-1:0] cpl_dest_id,
  output logic               cpl_is_load,
  output logic               err_valid,
  output logic [ID_BITS-1:0] err_dest_id,
  output logic               busy
);

  localparam int unsigned QW  = $clog2(DEPTH);
  // A single-entry tracker still gets a 1-bit index so the pointer slices stay legal.
  localparam int unsigned OW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OSZ = 1 << OW;
  localparam logic [AW+WB-1:0] ALIGN_MASK = (AW + WB)'((1 << WB) - 1);

  typedef struct packed {
    logic               op;
    logic [1:0]         mode;
    logic [2:0]         sew;
    logic [2:0]         idx_sew;
    logic [AW-1:0]      addr;
    logic [AW-1:0]      stride;
    logic [ID_BITS-1:0] dest_id;
  } cmd_t;

  cmd_t               r_q [DEPTH];
  logic [QW:0]        r_q_wr, r_q_rd;
  logic [ID_BITS:0]   r_o [OSZ];
  logic [OW:0]        r_o_wr, r_o_rd;
  logic               r_cpl_valid, r_cpl_is_load, r_err_valid;
  logic [ID_BITS-1:0] r_cpl_dest_id, r_err_dest_id;

  logic [QW:0]        w_q_cnt;
  logic [OW:0]        w_o_cnt;
  logic               w_q_empty, w_q_full, w_o_room;
  logic               w_acc, w_err, w_push, w_pop, w_done;
  cmd_t               w_new, w_head;

  assign w_q_cnt   = r_q_wr - r_q_rd;
  assign w_o_cnt   = r_o_wr - r_o_rd;
  assign w_q_empty = (w_q_cnt == '0);
  assign w_q_full  = (w_q_cnt == (QW + 1)'(DEPTH));
  assign w_o_room  = (w_o_cnt < (OW + 1)'(MAX_OUTSTANDING));
  assign w_head    = r_q[r_q_rd[QW-1:0]];

  assign w_acc  = in_valid & in_ready;
  assign w_err  = (in_load == in_store) | (in_mode == 2'd3) | ((in_addr & ALIGN_MASK) != '0);
  assign w_push = w_acc & ~w_err & ~flush;
  assign w_pop  = req_valid & req_ready & ~flush;
  assign w_done = done_in & (w_o_cnt != '0);

  always_comb begin
    w_new         = '0;
    w_new.op      = in_store;
    w_new.mode    = in_mode;
    w_new.sew     = in_sew;
    w_new.idx_sew = in_idx_sew;
    w_new.addr    = AW'(in_addr >> WB);
    w_new.stride  = AW'($signed(in_stride) >>> WB);
    w_new.dest_id = in_dest_id;
  end

  // Flush collapses the queue by catching the read pointer up; same-edge push/pop are suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_wr <= '0;
      r_q_rd <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (flush) begin
      r_q_rd <= r_q_wr;
    end else begin
      if (w_push) begin
        r_q[r_q_wr[QW-1:0]] <= w_new;
        r_q_wr              <= r_q_wr + 1'b1;
      end
      if (w_pop) r_q_rd <= r_q_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_wr <= '0;
      r_o_rd <= '0;
      for (int unsigned i = 0; i < OSZ; i++) r_o[i] <= '0;
    end else begin
      if (w_pop) begin
        r_o[r_o_wr[OW-1:0]] <= {w_head.dest_id, ~w_head.op};
        r_o_wr              <= r_o_wr + 1'b1;
      end
      if (w_done) r_o_rd <= r_o_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpl_valid   <= 1'b0;
      r_cpl_dest_id <= '0;
      r_cpl_is_load <= 1'b0;
      r_err_valid   <= 1'b0;
      r_err_dest_id <= '0;
    end else begin
      r_cpl_valid <= w_done;
      if (w_done) {r_cpl_dest_id, r_cpl_is_load} <= r_o[r_o_rd[OW-1:0]];
      r_err_valid <= w_acc & w_err;
      if (w_acc & w_err) r_err_dest_id <= in_dest_id;
    end
  end

  assign in_ready      = ~w_q_full;
  assign req_valid     = ~w_q_empty & w_o_room;
  assign req_operation = w_head.op;
  assign req_mode      = w_head.mode;
  assign req_sew       = w_head.sew;
  assign req_idx_sew   = w_head.idx_sew;
  assign req_addr      = w_head.addr;
  assign req_stride    = w_head.stride;
  assign cpl_valid     = r_cpl_valid;
  assign cpl_dest_id   = r_cpl_dest_id;
  assign cpl_is_load   = r_cpl_is_load;
  assign err_valid     = r_err_valid;
  assign err_dest_id   = r_err_dest_id;
  assign busy          = ~w_q_empty | (w_o_cnt != '0);

endmodule

// File: tb/tb_vmem_issue_queue.sv
// Bench for vmem_issue_queue: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based reference model of the command and outstanding lists.
module tb_vmem_issue_queue;
  localparam int AW = 15;
  localparam int WB = 2;
  localparam int DEPTH = 4;
  localparam int MO = 2;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_load = 0, in_store = 0;
  logic [1:0] in_mode = 0;
  logic [2:0] in_sew = 0, in_idx_sew = 0;
  logic [AW+WB-1:0] in_addr = 0, in_stride = 0;
  logic [4:0] in_dest_id = 0;
  logic flush = 0, req_valid, req_ready = 0, req_operation;
  logic [1:0] req_mode;
  logic [2:0] req_sew, req_idx_sew;
  logic [AW-1:0] req_addr, req_stride;
  logic done_in = 0, cpl_valid, cpl_is_load, err_valid, busy;
  logic [4:0] cpl_dest_id, err_dest_id;

  vmem_issue_queue #(.ADDR_RANGE(32768), .MEMORY_BITS(32), .DEPTH(DEPTH),
                     .MAX_OUTSTANDING(MO), .ID_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_mode(in_mode), .in_sew(in_sew),
    .in_idx_sew(in_idx_sew), .in_addr(in_addr), .in_stride(in_stride),
    .in_dest_id(in_dest_id), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_operation(req_operation), .req_mode(req_mode), .req_sew(req_sew),
    .req_idx_sew(req_idx_sew), .req_addr(req_addr), .req_stride(req_stride),
    .done_in(done_in), .cpl_valid(cpl_valid), .cpl_dest_id(cpl_dest_id),
    .cpl_is_load(cpl_is_load), .err_valid(err_valid), .err_dest_id(err_dest_id), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    bit op; bit [1:0] mode; bit [2:0] sew, isew;
    bit [AW-1:0] addr, stride; bit [4:0] dest;
  } exp_cmd_t;
  typedef struct { bit [4:0] dest; bit is_load; } cpl_t;

  exp_cmd_t exp_req[$];
  cpl_t     mdl_out[$];
  cpl_t     exp_cpl[$];
  bit [4:0] exp_err[$];

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word stride is the floor of byte stride / bytes-per-word, kept to AW bits.
  function automatic exp_cmd_t model_cmd();
    exp_cmd_t e;
    int s, q;
    s = in_stride[AW+WB-1] ? int'(in_stride) - (1 << (AW + WB)) : int'(in_stride);
    q = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    e.op = in_store; e.mode = in_mode; e.sew = in_sew; e.isew = in_idx_sew;
    e.addr = AW'(int'(in_addr) / 4);
    e.stride = q[AW-1:0];
    e.dest = in_dest_id;
    return e;
  endfunction

  function automatic bit is_bad();
    return (in_load == in_store) || (in_mode == 2'd3) || (int'(in_addr) % 4 != 0);
  endfunction

  int qn, on;
  bit do_issue;
  exp_cmd_t e_m;
  cpl_t c_m;
  bit [4:0] id_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_req.delete(); mdl_out.delete(); exp_cpl.delete(); exp_err.delete();
    end else begin
      qn = exp_req.size();
      on = mdl_out.size();
      if (exp_cpl.size() > 0) begin
        c_m = exp_cpl.pop_front();
        chk("cpl_valid", cpl_valid, 1);
        chk("cpl_dest_id", cpl_dest_id, c_m.dest);
        chk("cpl_is_load", cpl_is_load, c_m.is_load);
      end else chk("cpl_idle", cpl_valid, 0);
      if (exp_err.size() > 0) begin
        id_m = exp_err.pop_front();
        chk("err_valid", err_valid, 1);
        chk("err_dest_id", err_dest_id, id_m);
      end else chk("err_idle", err_valid, 0);
      chk("req_valid", req_valid, (qn > 0 && on < MO));
      chk("in_ready", in_ready, (qn < DEPTH));
      chk("busy", busy, (qn > 0 || on > 0));
      do_issue = (qn > 0) && (on < MO) && req_ready && !flush;
      if (done_in && on > 0) exp_cpl.push_back(mdl_out.pop_front());
      if (do_issue) begin
        e_m = exp_req.pop_front();
        chk("req_operation", req_operation, e_m.op);
        chk("req_mode", req_mode, e_m.mode);
        chk("req_sew", req_sew, e_m.sew);
        chk("req_idx_sew", req_idx_sew, e_m.isew);
        chk("req_addr", req_addr, e_m.addr);
        chk("req_stride", req_stride, e_m.stride);
        c_m.dest = e_m.dest; c_m.is_load = !e_m.op;
        mdl_out.push_back(c_m);
      end
      if (flush) exp_req.delete();
      if (in_valid && qn < DEPTH) begin
        if (is_bad()) exp_err.push_back(in_dest_id);
        else if (!flush) exp_req.push_back(model_cmd());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit ld, input bit st, input bit [1:0] md,
                      input bit [AW+WB-1:0] ad, input bit [AW+WB-1:0] sd, input bit [4:0] id);
    bit ok = 0;
    in_valid = 1; in_load = ld; in_store = st; in_mode = md;
    in_sew = 3'd2; in_idx_sew = 3'd1; in_addr = ad; in_stride = sd; in_dest_id = id;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_ready_timeout", 0, 1);
    else tick();
    in_valid = 0;
  endtask

  task automatic done_pulse();
    done_in = 1; tick(); done_in = 0; tick();
  endtask

  task automatic setup_busy();
    req_ready = 1;
    send(1, 0, 0, 17'h300, 0, 5'd1);
    tick();
    req_ready = 0;
    send(1, 0, 0, 17'h304, 0, 5'd2);
    send(0, 1, 1, 17'h308, 17'h10, 5'd3);
    send(1, 0, 2, 17'h30C, 0, 5'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    rst_n = 1;
    tick();

    // Unit-stride load
    req_ready = 1;
    send(1, 0, 0, 17'h40, 0, 5'd7);
    chk("t1_req_valid", req_valid, 1);
    chk("t1_req_addr", req_addr, 15'h10);
    chk("t1_req_op", req_operation, 0);
    repeat (4) tick();
    done_in = 1; tick(); done_in = 0;
    chk("t1_cpl_valid", cpl_valid, 1);
    chk("t1_cpl_dest", cpl_dest_id, 7);
    chk("t1_cpl_load", cpl_is_load, 1);
    tick();

    // Negative strided store
    send(0, 1, 1, 17'h100, 17'h1FFF8, 5'd3);
    chk("t2_req_stride", req_stride, 15'h7FFE);
    chk("t2_req_op", req_operation, 1);
    tick();
    done_pulse();

    // Backpressure and outstanding limit
    req_ready = 0;
    for (int i = 0; i < 4; i++) send(1, 0, 0, 17'(32'h200 + 16 * i), 0, 5'(10 + i));
    chk("t3_full", in_ready, 0);
    chk("t3_head_addr", req_addr, 15'h80);
    repeat (3) tick();
    chk("t3_stable_addr", req_addr, 15'h80);
    chk("t3_stable_valid", req_valid, 1);
    req_ready = 1;
    tick(); tick();
    chk("t3_limit", req_valid, 0);
    chk("t3_ready_again", in_ready, 1);
    repeat (4) done_pulse();
    repeat (2) tick();
    chk("t3_idle", busy, 0);

    // Rejected commands
    send(1, 1, 0, 17'h40, 0, 5'd21);
    chk("t4_err_ld_st", err_valid, 1);
    chk("t4_err_id1", err_dest_id, 21);
    tick();
    chk("t4_err_pulse", err_valid, 0);
    send(1, 0, 0, 17'h42, 0, 5'd22);
    chk("t4_err_align", err_dest_id, 22);
    send(0, 1, 3, 17'h40, 0, 5'd23);
    chk("t4_err_mode", err_dest_id, 23);
    chk("t4_busy", busy, 0);
    tick();

    // Flush with one outstanding op
    setup_busy();
    flush = 1; tick(); flush = 0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_req_valid", req_valid, 0);
    chk("t5_busy_out", busy, 1);
    done_pulse();
    chk("t5_idle", busy, 0);

    // Reset mid-operation
    setup_busy();
    rst_n = 0; tick();
    chk("t6_in_ready", in_ready, 1);
    chk("t6_req_valid", req_valid, 0);
    chk("t6_busy", busy, 0);
    rst_n = 1; tick();
    done_in = 1; tick(); done_in = 0;
    chk("t6_no_cpl", cpl_valid, 0);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      in_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      in_load = (r < 5) || (r == 9); in_store = (r >= 5);
      in_mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_sew = 3'($urandom); in_idx_sew = 3'($urandom);
      in_addr = 17'($urandom);
      if ($urandom_range(0, 4) != 0) in_addr[1:0] = 2'b00;
      in_stride = 17'($urandom);
      in_dest_id = 5'($urandom);
      flush = ($urandom_range(0, 29) == 0);
      req_ready = !flush && ($urandom_range(0, 9) < 7);
      done_in = ($urandom_range(0, 9) < 3);
      tick();
    end
    in_valid = 0; flush = 0; done_in = 0; req_ready = 1;
    for (int i = 0; i < 100 && busy; i++) done_pulse();
    chk("drain_busy", busy, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
